wboled_fifo: RTL

//  Wishbone-slave controller for the Nexys-Video SSD1306-style B/W OLED (SPI, no MISO, plus D/Cn line), successor to the

---
 rtl/wboled_pkg.sv | 44 ++++
 rtl/wboled_fifo_if.sv | 30 +++
 rtl/oledspi_serializer.sv | 105 ++++++++++
 rtl/wboled_fifo.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/wboled_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wboled_pkg                                                      |
// | Purpose  : Shared constants, types and helpers for the FIFO-based OLED    |
// |            Wishbone controller: register map, serializer state encoding,  |
// |            queue entry width and STATUS bit positions.                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package wboled_pkg;

   // Register map (i_wb_addr)
   localparam logic [1:0] ADR_STATUS = 2'b00;
   localparam logic [1:0] ADR_CMD    = 2'b01;
   localparam logic [1:0] ADR_DATA   = 2'b10;
   localparam logic [1:0] ADR_PWR    = 2'b11;

   // Queue entry: {dcn, cnt[1:0], bytes[23:0]}
   localparam int ENTRY_W = 27;

   // STATUS register bit positions
   localparam int STAT_OVF      = 31;
   localparam int STAT_BUSY     = 30;
   localparam int STAT_EMPTY    = 29;
   localparam int STAT_FULL     = 28;
   localparam int STAT_FILL_LSB = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_GAP   = 2'd3
   } ser_state_t;

   // Number of bits to shift for an entry's byte-count field.
   function automatic logic [4:0] entry_nbits(input logic [1:0] cnt);
      case (cnt)
         2'd0:    return 5'd8;
         2'd1:    return 5'd16;
         default: return 5'd24;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/wboled_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wboled_fifo_if                                                  |
// | Purpose  : Pipelined Wishbone bus bundle for the OLED FIFO controller.    |
// |            slave modport : the controller; master modport : the CPU/DMA.  |
// |   i_wb_cyc/stb/we, i_wb_addr[1:0], i_wb_data[31:0]  master -> slave       |
// |   o_wb_stall, o_wb_ack, o_wb_data[31:0]              slave  -> master      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface wboled_fifo_if;
   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic [1:0]  i_wb_addr;
   logic [31:0] i_wb_data;
   logic        o_wb_stall;
   logic        o_wb_ack;
   logic [31:0] o_wb_data;

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
      output o_wb_stall, o_wb_ack, o_wb_data
   );

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
      input  o_wb_stall, o_wb_ack, o_wb_data
   );
endinterface
`default_nettype wire

// File: rtl/oledspi_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : oledspi_serializer                                              |
// | Purpose  : Shifts one queued entry (1..3 bytes, MSB first) out over a     |
// |            write-only SPI link, then holds CS high for one bit period.    |
// | Ports    : i_clk, i_reset   clock / sync active-high reset               |
// |            i_stb             start request (only honoured while idle)     |
// |            i_entry[25:0]     {cnt[1:0], bytes[23:0]}, valid in LOAD       |
// |            o_busy            state != IDLE                                |
// |            o_sck/o_mosi/o_cs_n  SPI pins (sck idles high)                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module oledspi_serializer
   import wboled_pkg::*;
#(
   parameter int CBITS = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stb,
   input  logic [25:0] i_entry,
   output logic        o_busy,
   output logic        o_sck,
   output logic        o_mosi,
   output logic        o_cs_n
);

   localparam logic [CBITS-1:0] c_div_max     = '1;
   localparam logic [CBITS-1:0] c_div_half_m1 = CBITS'(2**(CBITS-1) - 1);

   ser_state_t  r_state, w_state_next;
   logic [CBITS-1:0] r_div;
   logic [4:0]  r_bits_left;
   logic [23:0] r_sreg, w_load_sreg;
   logic        r_sck, r_mosi, r_cs_n;
   logic        w_bit_end;

   always_comb begin
      w_bit_end    = (r_div == c_div_max);
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (i_stb) w_state_next = S_LOAD;
         S_LOAD:  w_state_next = S_SHIFT;
         S_SHIFT: if (w_bit_end && r_bits_left == 5'd1) w_state_next = S_GAP;
         S_GAP:   if (w_bit_end) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase

      // Left-align the payload so the first bit to send is always bit 23.
      case (i_entry[25:24])
         2'd0:    w_load_sreg = {i_entry[7:0], 16'h0000};
         2'd1:    w_load_sreg = {i_entry[15:0], 8'h00};
         default: w_load_sreg = i_entry[23:0];
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_div       <= '0;
         r_bits_left <= '0;
         r_sreg      <= '0;
         r_sck       <= 1'b1;
         r_mosi      <= 1'b0;
         r_cs_n      <= 1'b1;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_LOAD: begin
               r_sreg      <= w_load_sreg;
               r_bits_left <= entry_nbits(i_entry[25:24]);
               r_div       <= '0;
               r_cs_n      <= 1'b0;
               r_sck       <= 1'b0;
               r_mosi      <= w_load_sreg[23];
            end
            S_SHIFT: begin
               r_div <= r_div + 1'b1;
               if (r_div == c_div_half_m1)
                  r_sck <= 1'b1;
               if (w_bit_end) begin
                  if (r_bits_left == 5'd1) begin
                     // Last bit: sck stays high into the gap.
                     r_cs_n <= 1'b1;
                  end else begin
                     r_sck       <= 1'b0;
                     r_sreg      <= {r_sreg[22:0], 1'b0};
                     r_mosi      <= r_sreg[22];
                     r_bits_left <= r_bits_left - 1'b1;
                  end
               end
            end
            S_GAP:   r_div <= r_div + 1'b1;
            default: begin end
         endcase
      end
   end

   assign o_busy = (r_state != S_IDLE);
   assign o_sck  = r_sck;
   assign o_mosi = r_mosi;
   assign o_cs_n = r_cs_n;

endmodule
`default_nettype wire

// File: rtl/wboled_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wboled_fifo                                                     |
// | Purpose  : Wishbone slave that queues OLED command/data entries in a FIFO |
// |            and streams them to an SSD1306-style display over SPI + D/Cn.  |
// | Ports    : i_clk, i_reset        clock / sync active-high reset           |
// |            wb (slave modport)    STATUS/CMD/DATA/PWR register bus         |
// |            o_sck, o_mosi, o_cs_n SPI pins                                 |
// |            o_dbit                D/Cn (1 = display data)                  |
// |            o_pwr[2:0]            {reset_n, vccen, pmoden}                 |
// |            o_int                 level interrupt: fill <= INT_LEVEL       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module wboled_fifo
   import wboled_pkg::*;
#(
   parameter int CBITS     = 4,
   parameter int LGFIFO    = 4,
   parameter int INT_LEVEL = 2
) (
   input  logic          i_clk,
   input  logic          i_reset,
   wboled_fifo_if.slave  wb,
   output logic          o_sck,
   output logic          o_mosi,
   output logic          o_dbit,
   output logic          o_cs_n,
   output logic [2:0]    o_pwr,
   output logic          o_int
);

   localparam int              c_depth_i   = 2**LGFIFO;
   localparam logic [LGFIFO:0] c_depth     = (LGFIFO+1)'(c_depth_i);
   localparam logic [LGFIFO:0] c_int_level = (LGFIFO+1)'(INT_LEVEL);

   logic [ENTRY_W-1:0] r_mem [c_depth_i];
   logic [LGFIFO-1:0]  r_wr_ptr, r_rd_ptr;
   logic [LGFIFO:0]    r_fill;
   logic [25:0]        r_rd_entry;
   logic               r_ovf, r_ack, r_dbit;
   logic [2:0]         r_pwr;
   logic [31:0]        r_rdata, w_status, w_rdata;
   logic               w_stb, w_wr, w_push_req, w_push, w_pop;
   logic               w_empty, w_full, w_ser_busy, w_ovf_set, w_ovf_clr;
   logic [ENTRY_W-1:0] w_entry;
   logic               w_unused;

   assign w_stb      = wb.i_wb_cyc & wb.i_wb_stb;
   assign w_wr       = w_stb & wb.i_wb_we;
   assign w_push_req = w_wr & ((wb.i_wb_addr == ADR_CMD) | (wb.i_wb_addr == ADR_DATA));
   assign w_empty    = (r_fill == '0);
   assign w_full     = (r_fill == c_depth);
   assign w_pop      = !w_empty & !w_ser_busy;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_push     = w_push_req & (!w_full | w_pop);
   assign w_ovf_set  = w_push_req & w_full & !w_pop;
   assign w_ovf_clr  = w_wr & (wb.i_wb_addr == ADR_STATUS) & wb.i_wb_data[31];
   assign w_entry    = {wb.i_wb_addr == ADR_DATA, wb.i_wb_data[25:0]};
   assign w_unused   = &{1'b0, wb.i_wb_data[30:26]};

   // Storage and registered read port; no reset needed on the array.
   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_entry;
      if (w_pop)
         r_rd_entry <= r_mem[r_rd_ptr][25:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
         r_ovf    <= 1'b0;
         r_ack    <= 1'b0;
         r_rdata  <= '0;
         r_pwr    <= '0;
         r_dbit   <= 1'b0;
      end else begin
         r_ack   <= w_stb;
         r_rdata <= (w_stb & !wb.i_wb_we) ? w_rdata : '0;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            // D/Cn is set before chip select falls and held until the next pop.
            r_dbit   <= r_mem[r_rd_ptr][ENTRY_W-1];
         end
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: begin end
         endcase
         // Setting has priority over a simultaneous clear.
         if (w_ovf_set)
            r_ovf <= 1'b1;
         else if (w_ovf_clr)
            r_ovf <= 1'b0;
         if (w_wr && wb.i_wb_addr == ADR_PWR)
            r_pwr <= (r_pwr & ~wb.i_wb_data[18:16]) | (wb.i_wb_data[2:0] & wb.i_wb_data[18:16]);
      end
   end

   always_comb begin
      w_status                             = '0;
      w_status[STAT_OVF]                   = r_ovf;
      w_status[STAT_BUSY]                  = w_ser_busy;
      w_status[STAT_EMPTY]                 = w_empty;
      w_status[STAT_FULL]                  = w_full;
      w_status[STAT_FILL_LSB +: LGFIFO+1]  = r_fill;
      w_status[2:0]                        = r_pwr;
      w_rdata = '0;
      case (wb.i_wb_addr)
         ADR_STATUS: w_rdata = w_status;
         ADR_PWR:    w_rdata = {29'h0, r_pwr};
         default:    w_rdata = '0;
      endcase
   end

   oledspi_serializer #(
      .CBITS (CBITS)
   ) u_ser (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_stb   (w_pop),
      .i_entry (r_rd_entry),
      .o_busy  (w_ser_busy),
      .o_sck   (o_sck),
      .o_mosi  (o_mosi),
      .o_cs_n  (o_cs_n)
   );

   assign wb.o_wb_stall = 1'b0;
   assign wb.o_wb_ack   = r_ack;
   assign wb.o_wb_data  = r_rdata;
   assign o_dbit        = r_dbit;
   assign o_pwr         = r_pwr;
   assign o_int         = (r_fill <= c_int_level);

endmodule
`default_nettype wire
